ex2: RTL and testbench
======================

Name: ex2

Overview:
- Registered 5-to-1 selector feeding an active-low 7-segment decoder.
- A 3-bit select (s2,s1,s0) picks one of five DATA_WIDTH-bit operands U, V, W, X or Y.
- The chosen value is decoded to a common-anode 7-segment pattern and registered on Clock.
- Sits at the board-display edge and drives one digit directly.

Parameters:
- DATA_WIDTH, 3, width of each operand. Legal range 1..4. Operands are zero-extended to 4 bits before decoding.

Ports:
- Clock  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- s2  input  1  select MSB.
- s1  input  1  select middle bit.
- s0  input  1  select LSB.
- U  input  DATA_WIDTH  operand for select 000.
- V  input  DATA_WIDTH  operand for select 001.
- W  input  DATA_WIDTH  operand for select 010.
- X  input  DATA_WIDTH  operand for select 011.
- Y  input  DATA_WIDTH  operand for selects 100, 101, 110, 111.
- seg7  output  7  active-low segments; bit order {g,f,e,d,c,b,a}, seg7[0]=a. Registered.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset:
  - At a rising edge of Clock with Reset=1, seg7 <= 7'h7F (all segments off).
  - Reset has priority over everything else.
  - Asserting Reset mid-operation blanks the display at the next edge.
  - The first edge after Reset deasserts loads a normal decoded value.
- Select mapping, combinational, sel={s2,s1,s0}:
  - 000 -> U, 001 -> V, 010 -> W, 011 -> X.
  - 1xx -> Y (all four codes with s2=1 select Y).
- Decode of the selected value, zero-extended to 4 bits. Values are seg7 as 7 bits; the 8-bit form with DP=1 is in brackets.
  - 0 -> 40 [C0]
  - 1 -> 79 [F9]
  - 2 -> 24 [A4]
  - 3 -> 30 [B0]
  - 4 -> 19 [99]
  - 5 -> 12 [92]
  - 6 -> 02 [82]
  - 7 -> 78 [F8]
  - 8 -> 00 [80]
  - 9 -> 10 [90]
  - A -> 08 [88]
  - b -> 03 [83]
  - C -> 46 [C6]
  - d -> 21 [A1]
  - E -> 06 [86]
  - F -> 0E [8E]
- Timing:
  - seg7 updates on every rising edge from the select and operand values sampled at that edge.
  - Latency is one cycle: inputs settled before edge N are reflected on seg7 just after edge N.
  - Input changes between edges have no effect until the next edge.
  - No handshake and no other state.
- X/Z on the select: no defined requirement. The decoder must use a full case with a default of 7'h7F, so no latches are inferred.

Decomposition:
- Shared package: 4-bit-to-segment constant table SEG_0..SEG_F and SEG_BLANK=7'h7F.
- One natural sub-module: seg7_decoder (4-bit in, 7-bit active-low out, purely combinational).
- The top level holds the select mux, zero-extension and output register.

Test Plan:
- Reset=1 for 2 edges with any inputs -> seg7=7'h7F. Release with sel=000, U=0 -> seg7=7'h40 after the next edge.
- sel=001, V=0, Y=1 -> seg7=7'h40 (V chosen, not Y). Then sel=100, Y=0, W=1 -> seg7=7'h40 (Y chosen).
- Sweep sel=000..011 with U=1, V=2, W=3, X=4 -> 7'h79, 7'h24, 7'h30, 7'h19 on successive edges.
- sel=101, 110, 111 with Y=5, 6, 7 and all other operands 0 -> 7'h12, 7'h02, 7'h78.
- Change U from 2 to 6 mid-cycle with sel=000 -> seg7 stays 7'h24 until the next edge, then becomes 7'h02. Assert Reset in the same cycle -> 7'h7F instead.
- 20 random sel/operand vectors, each checked one edge later against the mux+decode reference table.

Source files
------------

// File: rtl/ex2_pkg.sv
// Shared constants for the ex2 display path: digit width and the
// active-low 7-segment patterns, bit order {g,f,e,d,c,b,a}.
package ex2_pkg;

    // Every operand is widened to this many bits before decoding.
    localparam int DIGIT_W = 4;

    // Active-low common-anode patterns (0 = segment lit).
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_A     = 7'h08;
    localparam logic [6:0] SEG_B     = 7'h03;
    localparam logic [6:0] SEG_C     = 7'h46;
    localparam logic [6:0] SEG_D     = 7'h21;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_F     = 7'h0E;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Select codes for the operand mux; any code with the MSB set picks Y.
    typedef enum logic [2:0] {
        SEL_U = 3'b000,
        SEL_V = 3'b001,
        SEL_W = 3'b010,
        SEL_X = 3'b011,
        SEL_Y = 3'b100
    } sel_e;

endpackage : ex2_pkg

// File: rtl/ex2_seg7_decoder.sv
// Purely combinational hex digit to active-low 7-segment decoder.
module seg7_decoder
    import ex2_pkg::*;
(
    input  logic [DIGIT_W-1:0] i_digit,
    output logic [6:0]         o_seg
);

    // Full case with a blanking default so no latch can be inferred and
    // unknown inputs show an empty digit rather than a stale pattern.
    always_comb begin
        o_seg = SEG_BLANK;
        case (i_digit)
            4'h0:    o_seg = SEG_0;
            4'h1:    o_seg = SEG_1;
            4'h2:    o_seg = SEG_2;
            4'h3:    o_seg = SEG_3;
            4'h4:    o_seg = SEG_4;
            4'h5:    o_seg = SEG_5;
            4'h6:    o_seg = SEG_6;
            4'h7:    o_seg = SEG_7;
            4'h8:    o_seg = SEG_8;
            4'h9:    o_seg = SEG_9;
            4'hA:    o_seg = SEG_A;
            4'hB:    o_seg = SEG_B;
            4'hC:    o_seg = SEG_C;
            4'hD:    o_seg = SEG_D;
            4'hE:    o_seg = SEG_E;
            4'hF:    o_seg = SEG_F;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule : seg7_decoder

// File: rtl/ex2.sv
// Registered 5-to-1 operand selector driving one common-anode digit.
// Latency is one clock: inputs present at a rising edge of Clock show on
// seg7 just after that edge. No handshake; the display simply follows.
module ex2
    import ex2_pkg::*;
#(
    parameter int DATA_WIDTH = 3   // 1..4
)
(
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  s2,
    input  logic                  s1,
    input  logic                  s0,
    input  logic [DATA_WIDTH-1:0] U,
    input  logic [DATA_WIDTH-1:0] V,
    input  logic [DATA_WIDTH-1:0] W,
    input  logic [DATA_WIDTH-1:0] X,
    input  logic [DATA_WIDTH-1:0] Y,
    output logic [6:0]            seg7
);

    logic [2:0]            w_sel;
    logic [DATA_WIDTH-1:0] w_operand;
    logic [DIGIT_W-1:0]    w_digit;
    logic [6:0]            w_seg;
    logic [6:0]            r_seg7;

    assign w_sel = {s2, s1, s0};

    // Operand mux: the four low codes pick U..X, every code with s2 set picks Y.
    always_comb begin
        w_operand = Y;
        case (w_sel)
            SEL_U:   w_operand = U;
            SEL_V:   w_operand = V;
            SEL_W:   w_operand = W;
            SEL_X:   w_operand = X;
            default: w_operand = Y;
        endcase
    end

    // Zero-extend to a full hex digit; written as a partial overwrite so it
    // stays legal when DATA_WIDTH equals the digit width.
    always_comb begin
        w_digit = '0;
        w_digit[DATA_WIDTH-1:0] = w_operand;
    end

    seg7_decoder u_decoder (
        .i_digit (w_digit),
        .o_seg   (w_seg)
    );

    // Output register; reset blanks the digit and wins over new data.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_seg7 <= SEG_BLANK;
        end else begin
            r_seg7 <= w_seg;
        end
    end

    assign seg7 = r_seg7;

endmodule : ex2

// File: tb/tb_ex2.sv
// Directed and random bench for ex2 with a table-driven reference model.
module tb_ex2;

    localparam int DW = 3;

    logic          Clock;
    logic          Reset;
    logic          s2, s1, s0;
    logic [DW-1:0] U, V, W, X, Y;
    logic [6:0]    seg7;

    int checks = 0;
    int errors = 0;

    // Reference glyphs, indexed by digit value.
    logic [6:0] glyph [16];

    ex2 #(.DATA_WIDTH(DW)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .s2    (s2),
        .s1    (s1),
        .s0    (s0),
        .U     (U),
        .V     (V),
        .W     (W),
        .X     (X),
        .Y     (Y),
        .seg7  (seg7)
    );

    // Clock: 10 time-unit period.
    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Reference: pick operand by select code, then look up the glyph.
    function automatic logic [6:0] model(input logic [2:0] sel,
                                         input logic [DW-1:0] u, v, w, x, y);
        int val;
        if (sel >= 3'd4)      val = int'(y);
        else if (sel == 3'd0) val = int'(u);
        else if (sel == 3'd1) val = int'(v);
        else if (sel == 3'd2) val = int'(w);
        else                  val = int'(x);
        return glyph[val];
    endfunction

    task automatic check(input string tag, input logic [6:0] exp);
        checks++;
        assert (seg7 === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, seg7, exp);
        end
    endtask

    task automatic drive(input logic [2:0] sel, input logic [DW-1:0] u, v, w, x, y);
        {s2, s1, s0} = sel;
        U = u; V = v; W = w; X = x; Y = y;
    endtask

    // Advance one edge and move to a point well after it.
    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    initial begin
        logic [2:0]    rsel;
        logic [DW-1:0] ru, rv, rw, rx, ry;

        glyph = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

        // Reset for two edges with arbitrary inputs.
        Reset = 1'b1;
        drive(3'b011, 3'd5, 3'd6, 3'd7, 3'd1, 3'd2);
        step();
        check("reset_edge1", 7'h7F);
        step();
        check("reset_edge2", 7'h7F);

        // Release with sel=000, U=0.
        drive(3'b000, 3'd0, 3'd3, 3'd3, 3'd3, 3'd3);
        Reset = 1'b0;
        step();
        check("release_u0", 7'h40);

        // V chosen over Y, then Y chosen over W.
        drive(3'b001, 3'd4, 3'd0, 3'd4, 3'd4, 3'd1);
        step();
        check("sel001_v", 7'h40);
        drive(3'b100, 3'd4, 3'd4, 3'd1, 3'd4, 3'd0);
        step();
        check("sel100_y", 7'h40);

        // Sweep the four low codes.
        for (int i = 0; i < 4; i++) begin
            drive(3'(i), 3'd1, 3'd2, 3'd3, 3'd4, 3'd0);
            step();
            check($sformatf("sweep_sel%0d", i), model(3'(i), 3'd1, 3'd2, 3'd3, 3'd4, 3'd0));
        end

        // Upper codes all select Y.
        drive(3'b101, 3'd0, 3'd0, 3'd0, 3'd0, 3'd5);
        step();
        check("sel101_y5", 7'h12);
        drive(3'b110, 3'd0, 3'd0, 3'd0, 3'd0, 3'd6);
        step();
        check("sel110_y6", 7'h02);
        drive(3'b111, 3'd0, 3'd0, 3'd0, 3'd0, 3'd7);
        step();
        check("sel111_y7", 7'h78);

        // Mid-cycle input change is invisible until the next edge.
        drive(3'b000, 3'd2, 3'd0, 3'd0, 3'd0, 3'd0);
        step();
        check("mid_before", 7'h24);
        U = 3'd6;
        #2;
        check("mid_hold", 7'h24);
        step();
        check("mid_after", 7'h02);

        // Same scenario but reset asserted in the changing cycle.
        U = 3'd2;
        step();
        check("rst_mid_before", 7'h24);
        U = 3'd6;
        Reset = 1'b1;
        #2;
        check("rst_mid_hold", 7'h24);
        step();
        check("rst_mid_blank", 7'h7F);
        Reset = 1'b0;
        step();
        check("rst_mid_recover", 7'h02);

        // Random vectors against the reference model.
        for (int n = 0; n < 20; n++) begin
            rsel = 3'($urandom_range(0, 7));
            ru   = DW'($urandom_range(0, (1 << DW) - 1));
            rv   = DW'($urandom_range(0, (1 << DW) - 1));
            rw   = DW'($urandom_range(0, (1 << DW) - 1));
            rx   = DW'($urandom_range(0, (1 << DW) - 1));
            ry   = DW'($urandom_range(0, (1 << DW) - 1));
            drive(rsel, ru, rv, rw, rx, ry);
            step();
            check($sformatf("rand%0d_sel%0d", n, rsel), model(rsel, ru, rv, rw, rx, ry));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_ex2
